anim_seq: RTL and testbench
===========================

// Module: anim_seq
// PURPOSE
//  Autonomous playlist controller for the LED animation top: drives its mode[1:0] and en inputs.
//  Steps through the enabled patterns (0..3) in ascending cyclic order; each is shown for a
//  programmable dwell time. Accepts start/stop/next pulses and a hold level from the panel logic.
// PARAMETERS
//  TICK_DIV     50000  clk cycles per dwell tick (1 ms at 50 MHz)
//  DWELL_DEF    2000   dwell in ticks used when dwell input == 0
//  BLANK_TICKS  100    blank gap length in ticks (used only with ANIM_SEQ_BLANK_EN)
// PORTS
//  clk       in   1   system clock, rising edge
//  rst       in   1   reset, synchronous and active-low
//  start     in   1   pulse: begin playback from first enabled mode
//  stop      in   1   pulse: end playback, return to IDLE
//  next      in   1   pulse: advance to next enabled mode immediately
//  hold      in   1   level: freeze dwell timing, current pattern stays shown
//  seq_mask  in   4   bit i=1 -> mode i is in the playlist
//  dwell     in   16  dwell in ticks per pattern; 0 -> DWELL_DEF
//  mode      out  2   pattern select to animation top
//  en        out  1   output enable to animation top
//  busy      out  1   1 when not IDLE
//  wrap      out  1   1-cycle pulse when playlist wraps (advance to a lower mode index)
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state IDLE, mode=0, en=0, busy=0, wrap=0, counters cleared.
//  - FSM: IDLE -> RUN on start with seq_mask!=0; RUN -> RUN (advance); RUN/BLANK -> IDLE on stop.
//    start with seq_mask==0 ignored. start while busy ignored. stop+start same cycle -> IDLE.
//  - Latency: start at edge N -> mode=lowest set bit of seq_mask, en=1, busy=1 from edge N+1.
//  - Timing: prescaler 0..TICK_DIV-1, tick on terminal count; dwell counter counts ticks.
//    dwell_eff latched at each pattern load (later dwell changes apply to next pattern).
//    Prescaler and dwell counter cleared on every load -> pattern shown exactly dwell_eff*TICK_DIV cycles.
//  - Advance: on (tick && dwell_cnt==dwell_eff-1) or next. Both same cycle -> single advance.
//    Next mode = first set bit of seq_mask above current, cyclic; if only current bit set, mode
//    unchanged but timers reload. wrap=1 for one cycle when new mode index <= old index (advance).
//  - hold=1: prescaler and dwell counter frozen; next and stop still honoured.
//  - seq_mask goes 0 while RUN -> IDLE next cycle (en=0). Current mode masked out mid-run ->
//    advance on next cycle as if next pulsed.
//  - IDLE: en=0, mode holds last value. All arithmetic unsigned; dwell_cnt width 16.
// CONFIGURATION
//  ANIM_SEQ_BLANK_EN defined: every advance enters BLANK for BLANK_TICKS ticks: mode already =
//    new mode, en=0; then RUN with fresh dwell. next during BLANK ends BLANK at once (no extra step);
//    hold freezes BLANK timing. Start goes straight to RUN (no leading blank).
//  Undefined: no BLANK state; advance is a single-cycle mode change with en held 1.
// STRUCTURE
//  anim_pkg: state enum (IDLE, RUN, BLANK), MODE_W=2, N_MODES=4, next-enabled-mode function.
//  Sub-module anim_tick: TICK_DIV prescaler with clr and freeze inputs, tick output.
//  FSM, dwell counter, mode selection in anim_seq.
// TESTING (bench params TICK_DIV=4, DWELL_DEF=3, BLANK_TICKS=2)
//  1. Reset held 3 cycles -> mode=0, en=0, busy=0, wrap=0.
//  2. mask=1111, dwell=0, start @0 -> mode 0 en=1 @1; mode 1 @13, 2 @25, 3 @37, 0 @49 with wrap=1 @49.
//  3. mask=1010, dwell=2, start -> modes 1,3,1 each 8 cycles; wrap pulse on 3->1 only.
//  4. hold high 20 cycles mid-pattern -> that pattern lasts 12+20=32 cycles; next during hold advances.
//  5. next on expiry cycle -> one advance; stop+start same cycle -> IDLE, en=0; mask->0 -> IDLE next cycle.
//  6. ANIM_SEQ_BLANK_EN, mask=0011 -> after 12 cycles mode=1 en=0 for 8 cycles, then en=1 for 12.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared types and helpers for the animation playlist sequencer (anim_seq).
package anim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, BLANK} state_t;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned N_MODES = 4;

  // First enabled mode strictly after cur, cyclic; returns cur if it is the only one enabled.
  function automatic logic [MODE_W-1:0] next_mode(input logic [N_MODES-1:0] mask,
                                                  input logic [MODE_W-1:0]  cur);
    logic [MODE_W-1:0] res;
    logic [MODE_W-1:0] idx;
    logic              found;
    res   = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_MODES; i++) begin
      idx = cur + MODE_W'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/anim_tick.sv
// Dwell-tick prescaler: counts 0..TICK_DIV-1, tick on terminal count; clr wins over freeze.
module anim_tick #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic freeze,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == CW'(TICK_DIV - 1));
  assign tick = w_tc && !freeze;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (!freeze) begin
      r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/anim_seq.sv
// Autonomous playlist controller driving mode/en of the LED animation top.
// Optional blank gap between patterns: define ANIM_SEQ_BLANK_EN.
module anim_seq
  import anim_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DWELL_DEF   = 2000,
  parameter int unsigned BLANK_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        next,
  input  logic        hold,
  input  logic [3:0]  seq_mask,
  input  logic [15:0] dwell,
  output logic [1:0]  mode,
  output logic        en,
  output logic        busy,
  output logic        wrap
);

`ifdef ANIM_SEQ_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  state_t            r_state;
  logic [MODE_W-1:0] r_mode;
  logic              r_en;
  logic              r_busy;
  logic              r_wrap;
  logic [15:0]       r_dwell_cnt;
  logic [15:0]       r_dwell_eff;

  logic              w_tick;
  logic              w_clr;
  logic              w_start_ok;
  logic              w_to_idle;
  logic              w_expire;
  logic              w_adv;
  logic              w_blank_done;
  logic [15:0]       w_dwell_new;
  logic [MODE_W-1:0] w_next_mode;
  logic [MODE_W-1:0] w_first_mode;

  always_comb begin
    w_dwell_new  = (dwell == '0) ? 16'(DWELL_DEF) : dwell;
    w_next_mode  = next_mode(seq_mask, r_mode);
    // Searching after the top index yields the lowest enabled mode.
    w_first_mode = next_mode(seq_mask, MODE_W'(N_MODES - 1));
    w_start_ok   = start && !stop && (seq_mask != '0);
    w_to_idle    = stop || (seq_mask == '0);
    w_expire     = w_tick && (r_dwell_cnt == r_dwell_eff - 16'd1);
    w_adv        = (r_state == RUN) && !w_to_idle && (next || w_expire || !seq_mask[r_mode]);
    w_blank_done = (r_state == BLANK) && !w_to_idle &&
                   (next || (w_tick && (r_dwell_cnt == 16'(BLANK_TICKS - 1))));
    w_clr        = (r_state == IDLE) || w_adv || w_blank_done;
  end

  anim_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_clr),
    .freeze (hold),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mode      <= '0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_wrap      <= 1'b0;
      r_dwell_cnt <= '0;
      r_dwell_eff <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state     <= RUN;
            r_mode      <= w_first_mode;
            r_en        <= 1'b1;
            r_busy      <= 1'b1;
            r_dwell_cnt <= '0;
            r_dwell_eff <= w_dwell_new;
          end
        end
        RUN: begin
          if (w_to_idle) begin
            r_state     <= IDLE;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_dwell_cnt <= '0;
          end else if (w_adv) begin
            r_mode      <= w_next_mode;
            r_wrap      <= (w_next_mode <= r_mode);
            r_dwell_cnt <= '0;
            if (BLANK_EN) begin
              r_state <= BLANK;
              r_en    <= 1'b0;
            end else begin
              r_dwell_eff <= w_dwell_new;
            end
          end else if (w_tick) begin
            r_dwell_cnt <= r_dwell_cnt + 16'd1;
          end
        end
        BLANK: begin
          // dwell counter doubles as the blank tick counter here
          if (w_to_idle) begin
            r_state     <= IDLE;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_dwell_cnt <= '0;
          end else if (w_blank_done) begin
            r_state     <= RUN;
            r_en        <= 1'b1;
            r_dwell_cnt <= '0;
            r_dwell_eff <= w_dwell_new;
          end else if (w_tick) begin
            r_dwell_cnt <= r_dwell_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mode = r_mode;
  assign en   = r_en;
  assign busy = r_busy;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_anim_seq.sv
// Scoreboard bench for anim_seq: cycle-budget reference model feeds an expectation queue.
module tb_anim_seq;

  localparam int unsigned TD = 4;
  localparam int unsigned DD = 3;
  localparam int unsigned BT = 2;

`ifdef ANIM_SEQ_BLANK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        next = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  seq_mask = '0;
  logic [15:0] dwell = '0;
  logic [1:0]  mode;
  logic        en;
  logic        busy;
  logic        wrap;

  anim_seq #(.TICK_DIV(TD), .DWELL_DEF(DD), .BLANK_TICKS(BT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .next     (next),
    .hold     (hold),
    .seq_mask (seq_mask),
    .dwell    (dwell),
    .mode     (mode),
    .en       (en),
    .busy     (busy),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic       en;
    logic       busy;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   vectors = 0;
  int   errors  = 0;

  // Reference model: remaining visible cycles of the current pattern or gap.
  bit m_busy  = 1'b0;
  bit m_blank = 1'b0;
  bit m_wrap  = 1'b0;
  int m_mode  = 0;
  int m_rem   = 0;

  function automatic int pick_next(input logic [3:0] m, input int cur);
    int lst[$];
    int res;
    bit found;
    for (int k = 0; k < 4; k++) if (m[k]) lst.push_back(k);
    res   = lst[0];
    found = 1'b0;
    foreach (lst[j]) begin
      if (!found && lst[j] > cur) begin
        res   = lst[j];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic int dwell_cycles(input logic [15:0] d);
    return ((d == 16'd0) ? int'(DD) : int'(d)) * int'(TD);
  endfunction

  task automatic step(input bit a_rst, input bit a_start, input bit a_stop, input bit a_next,
                      input bit a_hold, input logic [3:0] a_mask, input logic [15:0] a_dwell);
    int nm;
    @(negedge clk);
    rst = a_rst; start = a_start; stop = a_stop; next = a_next;
    hold = a_hold; seq_mask = a_mask; dwell = a_dwell;
    m_wrap = 1'b0;
    if (!a_rst) begin
      m_busy = 1'b0; m_blank = 1'b0; m_mode = 0; m_rem = 0;
    end else if (!m_busy) begin
      if (a_start && !a_stop && a_mask != 4'd0) begin
        m_busy = 1'b1; m_blank = 1'b0;
        m_mode = pick_next(a_mask, -1);
        m_rem  = dwell_cycles(a_dwell);
      end
    end else if (a_stop || a_mask == 4'd0) begin
      m_busy = 1'b0; m_blank = 1'b0;
    end else if (m_blank) begin
      if (a_next || (!a_hold && m_rem == 1)) begin
        m_blank = 1'b0;
        m_rem   = dwell_cycles(a_dwell);
      end else if (!a_hold) m_rem--;
    end else begin
      if (a_next || !a_mask[m_mode] || (!a_hold && m_rem == 1)) begin
        nm     = pick_next(a_mask, m_mode);
        m_wrap = (nm <= m_mode);
        m_mode = nm;
        if (BL) begin
          m_blank = 1'b1;
          m_rem   = int'(BT) * int'(TD);
        end else m_rem = dwell_cycles(a_dwell);
      end else if (!a_hold) m_rem--;
    end
    q.push_back('{mode: 2'(m_mode), en: m_busy && !m_blank, busy: m_busy, wrap: m_wrap});
  endtask

  task automatic run(input int n, input bit h, input logic [3:0] m, input logic [15:0] d);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, h, m, d);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        mon_a = '{mode: mode, en: en, busy: busy, wrap: wrap};
        vectors++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL t=%0t mode/en/busy/wrap got %0d/%0b/%0b/%0b exp %0d/%0b/%0b/%0b",
                   $time, mon_a.mode, mon_a.en, mon_a.busy, mon_a.wrap,
                   mon_e.mode, mon_e.en, mon_e.busy, mon_e.wrap);
        end
      end
    end
  end

  initial begin
    bit         s, p, n, h;
    logic [3:0] msk;
    logic [15:0] dw;
    int         guard;

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0);
    run(2, 1'b0, 4'h0, 16'd0);

    // full cycle 0->1->2->3->0 with default dwell
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 16'd0);
    run(55, 1'b0, 4'hF, 16'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 16'd0);

    // sparse mask, explicit dwell
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 16'd2);
    run(30, 1'b0, 4'hA, 16'd2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 16'd2);

    // hold stretch, then next while held
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 16'd0);
    run(5, 1'b0, 4'hF, 16'd0);
    run(20, 1'b1, 4'hF, 16'd0);
    run(10, 1'b0, 4'hF, 16'd0);
    run(3, 1'b1, 4'hF, 16'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 16'd0);
    run(3, 1'b1, 4'hF, 16'd0);
    run(20, 1'b0, 4'hF, 16'd0);

    // next coinciding with dwell expiry
    guard = 0;
    while (!(m_busy && !m_blank && m_rem == 1) && guard < 100) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 16'd0);
      guard++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 16'd0);
    run(6, 1'b0, 4'hF, 16'd0);
    // start while busy ignored, then stop+start same cycle
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 16'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 16'd0);
    run(3, 1'b0, 4'hF, 16'd0);
    // start with empty mask ignored
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'd1);
    run(2, 1'b0, 4'h0, 16'd1);
    // single-entry playlist reloads and wraps onto itself
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 16'd1);
    run(12, 1'b0, 4'h4, 16'd1);
    // mask out current mode mid-run, then empty mask
    run(2, 1'b0, 4'hB, 16'd1);
    run(3, 1'b0, 4'hC, 16'd1);
    run(2, 1'b0, 4'h0, 16'd1);

    h = 1'b0; msk = 4'hF; dw = 16'd0;
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 79) == 0);
      n = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) h = ~h;
      if ($urandom_range(0, 99) == 0) msk = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) dw = 16'($urandom_range(0, 3));
      step(($urandom_range(0, 399) != 0), s, p, n, h, msk, dw);
    end
    run(2, 1'b0, msk, dw);

    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending expectations got %0d exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
